// File: rtl/pc_sequencer_if.sv
// Fetch-PC sequencer bus: control inputs from the pipeline and the PC/status
// outputs of the sequencer, bundled so the core and the bench share one view.
//
// Handshake: there is no valid/ready pair on this bus. PcSel is the only
// qualifier and it qualifies BrPC in the same cycle; Stall, flag_halt and
// resume are level requests sampled on every rising clk edge. The sequencer
// never back-pressures its driver; every output is valid every cycle.
interface pc_sequencer_if #(
  parameter int PC_W = 9
);
  logic            Stall;
  logic            PcSel;
  logic [31:0]     BrPC;
  logic            flag_halt;
  logic            resume;
  logic [PC_W-1:0] Cur_PC;
  logic [31:0]     PC_Four;
  logic            Flush;
  logic            Halted;
  logic [15:0]     Redirects;
  logic            Misaligned;
  logic [1:0]      state_dbg;   // FSM state: 0=RUN, 1=FLUSH, 2=HALT

  // Pipeline / bench side
  modport master (
    output Stall, PcSel, BrPC, flag_halt, resume,
    input  Cur_PC, PC_Four, Flush, Halted, Redirects, Misaligned, state_dbg
  );

  // Sequencer side
  modport slave (
    input  Stall, PcSel, BrPC, flag_halt, resume,
    output Cur_PC, PC_Four, Flush, Halted, Redirects, Misaligned, state_dbg
  );
endinterface

// File: rtl/pc_sequencer.sv
// Fetch program-counter sequencer. Steps the PC by 4, takes branch redirects
// (followed by a fixed-length flush window), and parks at HALT_PC on a halt
// request or an illegal redirect target until resumed.
module pc_sequencer #(
  parameter int              PC_W      = 9,
  parameter int              FLUSH_CYC = 2,
  parameter logic [PC_W-1:0] HALT_PC   = 'h100
) (
  input  logic          clk,
  input  logic          reset,
  pc_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    FLUSH = 2'd1,
    HALT  = 2'd2
  } state_e;

  state_e          state;
  logic [2:0]      flush_cnt;
  logic [PC_W-1:0] cur_pc;
  logic            flush_q;
  logic            halted_q;
  logic [15:0]     redirects_q;
  logic            misaligned_q;

  logic [PC_W-1:0] pc_inc;
  logic            target_legal;

  // Next sequential PC wraps naturally at PC_W bits.
  assign pc_inc = cur_pc + PC_W'(4);

  // A target must be word aligned and fit inside the PC width.
  assign target_legal = (bus.BrPC[1:0] == 2'b00) && ((bus.BrPC >> PC_W) == 32'd0);

  // Main sequencer FSM; every output is registered alongside the state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= RUN;
      flush_cnt    <= 3'd0;
      cur_pc       <= '0;
      flush_q      <= 1'b0;
      halted_q     <= 1'b0;
      redirects_q  <= 16'd0;
      misaligned_q <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (bus.flag_halt) begin
            state    <= HALT;
            cur_pc   <= HALT_PC;
            halted_q <= 1'b1;
            flush_q  <= 1'b0;
          end else if (bus.PcSel) begin
            if (target_legal) begin
              state     <= FLUSH;
              cur_pc    <= bus.BrPC[PC_W-1:0];
              flush_cnt <= 3'(FLUSH_CYC);
              flush_q   <= 1'b1;
              if (redirects_q != 16'hFFFF) begin
                redirects_q <= redirects_q + 16'd1;
              end
            end else begin
              // Illegal target: park and remember why, without counting it.
              state        <= HALT;
              cur_pc       <= HALT_PC;
              halted_q     <= 1'b1;
              misaligned_q <= 1'b1;
            end
          end else if (!bus.Stall) begin
            cur_pc <= pc_inc;
          end
        end

        FLUSH: begin
          // Redirects are ignored here: the instructions being flushed
          // cannot legitimately steer fetch.
          if (bus.flag_halt) begin
            state     <= HALT;
            cur_pc    <= HALT_PC;
            flush_cnt <= 3'd0;
            flush_q   <= 1'b0;
            halted_q  <= 1'b1;
          end else begin
            // Stall freezes the PC but the flush window keeps counting.
            if (!bus.Stall) begin
              cur_pc <= pc_inc;
            end
            flush_cnt <= flush_cnt - 3'd1;
            if (flush_cnt == 3'd1) begin
              state   <= RUN;
              flush_q <= 1'b0;
            end
          end
        end

        HALT: begin
          if (bus.resume && !bus.flag_halt) begin
            state    <= RUN;
            cur_pc   <= '0;
            halted_q <= 1'b0;
          end
        end

        default: begin
          state    <= RUN;
          cur_pc   <= '0;
          flush_q  <= 1'b0;
          halted_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.Cur_PC     = cur_pc;
  assign bus.PC_Four    = 32'(cur_pc) + 32'd4;   // 32-bit, does not wrap at PC_W
  assign bus.Flush      = flush_q;
  assign bus.Halted     = halted_q;
  assign bus.Redirects  = redirects_q;
  assign bus.Misaligned = misaligned_q;
  assign bus.state_dbg  = state;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: increment, redirect/flush, stall, wrap,
// halt/resume, illegal targets and asynchronous reset in FLUSH and HALT.
module tb_pc_sequencer;

  localparam int PC_W = 9;

  localparam logic [1:0] S_RUN   = 2'd0;
  localparam logic [1:0] S_FLUSH = 2'd1;
  localparam logic [1:0] S_HALT  = 2'd2;

  logic clk;
  logic reset;

  int checks;
  int errors;
  logic [31:0] exp_q[$];

  pc_sequencer_if #(.PC_W(PC_W)) bus ();

  pc_sequencer #(
    .PC_W(PC_W),
    .FLUSH_CYC(2),
    .HALT_PC(9'h100)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- driver tasks ----------------
  task automatic idle_inputs();
    bus.Stall     = 1'b0;
    bus.PcSel     = 1'b0;
    bus.BrPC      = 32'd0;
    bus.flag_halt = 1'b0;
    bus.resume    = 1'b0;
  endtask

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic redirect(input logic [31:0] target, input logic stall);
    bus.PcSel = 1'b1;
    bus.BrPC  = target;
    bus.Stall = stall;
  endtask

  // ---------------- scoreboard ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_pc_from_queue(input string tag);
    logic [31:0] e;
    e = exp_q.pop_front();
    check(tag, 32'(bus.Cur_PC), e);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int stall_len;
    checks = 0;
    errors = 0;
    idle_inputs();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Reset state
    check("rst_pc",        32'(bus.Cur_PC),    32'h0);
    check("rst_flush",     32'(bus.Flush),     32'h0);
    check("rst_halted",    32'(bus.Halted),    32'h0);
    check("rst_redirects", 32'(bus.Redirects), 32'h0);
    check("rst_misalign",  32'(bus.Misaligned),32'h0);
    check("rst_state",     32'(bus.state_dbg), 32'(S_RUN));

    // Release reset; PC steps from the first edge afterwards
    reset = 1'b0;
    check("rel_pc0", 32'(bus.Cur_PC), 32'h0);
    exp_q.push_back(32'd4);
    exp_q.push_back(32'd8);
    exp_q.push_back(32'd12);
    for (int i = 0; i < 3; i++) begin
      step();
      check_pc_from_queue("inc_pc");
      check("inc_flush", 32'(bus.Flush), 32'h0);
    end
    check("inc_pc_four", bus.PC_Four, 32'd16);

    // Legal redirect to 0x40; a second PcSel during FLUSH is ignored
    redirect(32'h40, 1'b0);
    step();
    check("br_pc",        32'(bus.Cur_PC),    32'h40);
    check("br_flush1",    32'(bus.Flush),     32'h1);
    check("br_state",     32'(bus.state_dbg), 32'(S_FLUSH));
    check("br_redirects", 32'(bus.Redirects), 32'h1);
    redirect(32'h80, 1'b0);
    step();
    check("fl_pc2",       32'(bus.Cur_PC),    32'h44);
    check("fl_flush2",    32'(bus.Flush),     32'h1);
    check("fl_ign_redir", 32'(bus.Redirects), 32'h1);
    idle_inputs();
    step();
    check("fl_pc3",    32'(bus.Cur_PC), 32'h48);
    check("fl_flush3", 32'(bus.Flush),  32'h0);
    check("fl_state3", 32'(bus.state_dbg), 32'(S_RUN));
    step();
    check("fl_pc4",    32'(bus.Cur_PC), 32'h4C);
    check("fl_flush4", 32'(bus.Flush),  32'h0);

    // PcSel overrides Stall; stall then holds PC while the flush window runs out
    redirect(32'h80, 1'b1);
    step();
    check("ovr_pc",        32'(bus.Cur_PC),    32'h80);
    check("ovr_redirects", 32'(bus.Redirects), 32'h2);
    bus.PcSel = 1'b0;
    bus.Stall = 1'b1;
    step();
    check("stl_pc1",    32'(bus.Cur_PC), 32'h80);
    check("stl_flush1", 32'(bus.Flush),  32'h1);
    step();
    check("stl_pc2",    32'(bus.Cur_PC), 32'h80);
    check("stl_flush2", 32'(bus.Flush),  32'h0);
    stall_len = $urandom_range(1, 3);
    for (int i = 0; i < stall_len; i++) begin
      step();
      check("stl_pc_run", 32'(bus.Cur_PC), 32'h80);
    end
    idle_inputs();
    step();
    check("stl_release", 32'(bus.Cur_PC), 32'h84);

    // Wrap at PC_W while PC_Four keeps the carry
    redirect(32'h1F8, 1'b0);
    step();
    check("wr_pc0", 32'(bus.Cur_PC), 32'h1F8);
    idle_inputs();
    step();
    check("wr_pc1",   32'(bus.Cur_PC), 32'h1FC);
    check("wr_four",  bus.PC_Four,     32'h200);
    step();
    check("wr_pc2",   32'(bus.Cur_PC), 32'h000);
    check("wr_four2", bus.PC_Four,     32'h4);

    // Halt in the second FLUSH cycle
    redirect(32'h20, 1'b0);
    step();
    check("h_redirects", 32'(bus.Redirects), 32'h4);
    idle_inputs();
    step();
    check("h_pc_fl2",  32'(bus.Cur_PC), 32'h24);
    check("h_flush_2", 32'(bus.Flush),  32'h1);
    bus.flag_halt = 1'b1;
    step();
    check("h_pc",     32'(bus.Cur_PC),    32'h100);
    check("h_halted", 32'(bus.Halted),    32'h1);
    check("h_flush",  32'(bus.Flush),     32'h0);
    check("h_state",  32'(bus.state_dbg), 32'(S_HALT));
    // PcSel and Stall ignored in HALT
    bus.flag_halt = 1'b0;
    redirect(32'h40, 1'b1);
    step();
    check("h_ign_pc",  32'(bus.Cur_PC),    32'h100);
    check("h_ign_red", 32'(bus.Redirects), 32'h4);
    idle_inputs();
    // resume with halt still asserted stays halted
    bus.resume    = 1'b1;
    bus.flag_halt = 1'b1;
    step();
    check("h_stay_halted", 32'(bus.Halted), 32'h1);
    check("h_stay_pc",     32'(bus.Cur_PC), 32'h100);
    bus.flag_halt = 1'b0;
    step();
    check("res_pc",     32'(bus.Cur_PC), 32'h0);
    check("res_halted", 32'(bus.Halted), 32'h0);
    idle_inputs();
    step();
    check("res_inc", 32'(bus.Cur_PC), 32'h4);

    // flag_halt beats PcSel in RUN
    redirect(32'h40, 1'b0);
    bus.flag_halt = 1'b1;
    step();
    check("pri_pc",        32'(bus.Cur_PC),     32'h100);
    check("pri_halted",    32'(bus.Halted),     32'h1);
    check("pri_redirects", 32'(bus.Redirects),  32'h4);
    check("pri_misalign",  32'(bus.Misaligned), 32'h0);
    idle_inputs();
    bus.resume = 1'b1;
    step();
    idle_inputs();
    check("pri_res_pc", 32'(bus.Cur_PC), 32'h0);

    // Misaligned target
    redirect(32'h42, 1'b0);
    step();
    check("mis_flag",      32'(bus.Misaligned), 32'h1);
    check("mis_halted",    32'(bus.Halted),     32'h1);
    check("mis_pc",        32'(bus.Cur_PC),     32'h100);
    check("mis_redirects", 32'(bus.Redirects),  32'h4);
    check("mis_flush",     32'(bus.Flush),      32'h0);
    idle_inputs();
    bus.resume = 1'b1;
    step();
    idle_inputs();
    check("mis_res_pc",   32'(bus.Cur_PC),     32'h0);
    check("mis_sticky",   32'(bus.Misaligned), 32'h1);

    // Out-of-range target
    redirect(32'h400, 1'b0);
    step();
    check("oor_halted",    32'(bus.Halted),    32'h1);
    check("oor_pc",        32'(bus.Cur_PC),    32'h100);
    check("oor_redirects", 32'(bus.Redirects), 32'h4);
    idle_inputs();
    bus.resume = 1'b1;
    step();
    idle_inputs();
    check("oor_sticky", 32'(bus.Misaligned), 32'h1);

    // Asynchronous reset in the middle of FLUSH
    redirect(32'h40, 1'b0);
    step();
    idle_inputs();
    check("rf_flush_pre", 32'(bus.Flush), 32'h1);
    #3;
    reset = 1'b1;
    #1;
    check("rf_flush",    32'(bus.Flush),      32'h0);
    check("rf_pc",       32'(bus.Cur_PC),     32'h0);
    check("rf_state",    32'(bus.state_dbg),  32'(S_RUN));
    check("rf_misalign", 32'(bus.Misaligned), 32'h0);
    check("rf_redirs",   32'(bus.Redirects),  32'h0);
    step();
    check("rf_flush_hold", 32'(bus.Flush), 32'h0);
    reset = 1'b0;
    step();
    check("rf_first_inc", 32'(bus.Cur_PC), 32'h4);

    // Asynchronous reset in the middle of HALT
    bus.flag_halt = 1'b1;
    step();
    idle_inputs();
    check("rh_halted_pre", 32'(bus.Halted), 32'h1);
    #3;
    reset = 1'b1;
    #1;
    check("rh_halted", 32'(bus.Halted), 32'h0);
    check("rh_pc",     32'(bus.Cur_PC), 32'h0);
    step();
    reset = 1'b0;
    step();
    check("rh_first_inc", 32'(bus.Cur_PC), 32'h4);

    // ---------------- report ----------------
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
